// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: reads opcode (+ optional immediate) bytes from a
// registered-read instruction memory and issues them downstream via valid/ready.
module instr_fetch_unit #(
  parameter int                  ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [3:0]          OP_LOAD  = 4'b1001,
  parameter logic [3:0]          OP_STORE = 4'b1101,
  parameter logic [3:0]          OP_HLT   = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        instr,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              halted
);

  typedef enum logic [2:0] {
    F_ADDR1,
    F_DATA1,
    F_ADDR2,
    F_DATA2,
    F_ISSUE,
    F_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [7:0]        instr_reg, instr_next;
  logic [7:0]        imm_reg, imm_next;
  logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
  logic              instr_valid_reg, instr_valid_next;
  logic              halted_reg, halted_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= F_ADDR1;
      pc_reg          <= RESET_PC;
      instr_reg       <= 8'h00;
      imm_reg         <= 8'h00;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      imm_reg         <= imm_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
      halted_reg      <= halted_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    imm_next         = imm_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;
    halted_next      = halted_reg;
    case (state_reg)
      F_ADDR1: state_next = F_DATA1;
      F_DATA1: begin
        instr_next    = imem_rdata;
        instr_pc_next = pc_reg;
        imm_next      = 8'h00;
        pc_next       = pc_reg + PC_ONE;
        if (imem_rdata[7:4] == OP_HLT) begin
          state_next  = F_HALT;
          halted_next = 1'b1;
        end else if (imem_rdata[7:4] == OP_LOAD || imem_rdata[7:4] == OP_STORE) begin
          state_next = F_ADDR2;
        end else begin
          state_next = F_ISSUE;
        end
      end
      F_ADDR2: state_next = F_DATA2;
      F_DATA2: begin
        imm_next   = imem_rdata;
        pc_next    = pc_reg + PC_ONE;
        state_next = F_ISSUE;
      end
      F_ISSUE: begin
        // First cycle in ISSUE arms the valid register; handshake runs after that.
        if (!instr_valid_reg) begin
          instr_valid_next = 1'b1;
        end else if (instr_ready) begin
          instr_valid_next = 1'b0;
          state_next       = F_ADDR1;
          if (pc_load) pc_next = pc_load_val;
        end
      end
      F_HALT: begin
        instr_valid_next = 1'b0;
        halted_next      = 1'b1;
      end
      default: state_next = F_ADDR1;
    endcase
  end

  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign imm         = imm_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven program plus hand-written
// hold/redirect/wrap/halt/async-reset sequences, checked through a scoreboard queue.
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic [7:0] imm;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       halted;

  instr_fetch_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .imm(imm), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] imem [0:255];
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] exp_imm;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc;
    int         lat;
    logic [7:0] next_addr;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic push_exp(input logic [7:0] i, input logic [7:0] m, input logic [7:0] pc,
                          input int lat, input logic [7:0] nxt);
    exp_t e;
    e.instr = i; e.imm = m; e.pc = pc; e.lat = lat; e.next_addr = nxt;
    sb.push_back(e);
  endtask

  // Called at the negedge of the first F_ADDR1 cycle. Waits for valid, compares
  // against the scoreboard head, optionally stalls, then accepts (with optional redirect).
  task automatic do_instr(input logic ld, input logic [7:0] ld_val, input int hold);
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: got 0 entries expected >0");
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("latency@%0h", e.pc), n, e.lat);
    check($sformatf("instr@%0h", e.pc), instr, e.instr);
    check($sformatf("imm@%0h", e.pc), imm, e.imm);
    check($sformatf("instr_pc@%0h", e.pc), instr_pc, e.pc);
    for (int h = 0; h < hold; h++) begin
      instr_ready = 1'b0;
      pc_load     = (h == 2);
      pc_load_val = 8'h80;
      @(negedge clk);
      check($sformatf("hold%0d_stable", h), {instr_valid, instr, imm, instr_pc},
            {1'b1, e.instr, e.imm, e.pc});
    end
    instr_ready = 1'b1;
    pc_load     = ld;
    pc_load_val = ld_val;
    @(posedge clk);
    @(negedge clk);
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    check($sformatf("valid_drop@%0h", e.pc), instr_valid, 1'b0);
    check($sformatf("next_addr@%0h", e.pc), imem_addr, ld ? ld_val : e.next_addr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, imem_addr, 8'h00);
    check({tag, "_instr"}, instr, 8'h00);
    check({tag, "_imm"}, imm, 8'h00);
    check({tag, "_instr_pc"}, instr_pc, 8'h00);
    check({tag, "_valid"}, instr_valid, 1'b0);
    check({tag, "_halted"}, halted, 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    int   a;
    int   seen;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;

    vecs[0] = '{8'h16, 8'h00, 8'h00, 3};
    vecs[1] = '{8'h94, 8'h3C, 8'h3C, 5};
    vecs[2] = '{8'h25, 8'h00, 8'h00, 3};
    vecs[3] = '{8'hD8, 8'h77, 8'h77, 5};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 3};
    vecs[5] = '{8'hE1, 8'h00, 8'h00, 3};
    vecs[6] = '{8'hB3, 8'h00, 8'h00, 3};
    vecs[7] = '{8'h9F, 8'hAA, 8'hAA, 5};
    vecs[8] = '{8'h80, 8'h00, 8'h00, 3};

    repeat (2) @(negedge clk);
    check("reset_no_x", $isunknown({imem_addr, instr, imm, instr_pc, instr_valid, halted}), 1'b0);
    check_reset_outputs("reset");

    // Lay the table out as a contiguous program from address 0.
    a = 0;
    foreach (vecs[k]) begin
      int len;
      len = (vecs[k].exp_lat == 5) ? 2 : 1;
      imem[a] = vecs[k].b0;
      if (len == 2) imem[(a + 1) % 256] = vecs[k].b1;
      push_exp(vecs[k].b0, vecs[k].exp_imm, 8'(a), vecs[k].exp_lat, 8'(a + len));
      a = a + len;
    end
    imem[a] = 8'h31;
    push_exp(8'h31, 8'h00, 8'(a), 3, 8'(a + 1));
    imem[8'h40] = 8'h27;
    push_exp(8'h27, 8'h00, 8'h40, 3, 8'h41);

    rst_n = 1'b1;
    foreach (vecs[k]) do_instr(1'b0, 8'h00, 0);
    do_instr(1'b1, 8'h40, 5);

    // Ready and pc_load held high while not valid must be ignored until the handshake.
    imem[8'hFF] = 8'hD8;
    imem[8'h00] = 8'h20;
    push_exp(8'hD8, 8'h20, 8'hFF, 5, 8'h01);
    instr_ready = 1'b1;
    pc_load     = 1'b1;
    pc_load_val = 8'h99;
    do_instr(1'b1, 8'hFF, 0);
    do_instr(1'b0, 8'h00, 0);

    // Halt run.
    rst_n = 1'b0;
    imem[0] = 8'h16; imem[1] = 8'h94; imem[2] = 8'h3C;
    imem[3] = 8'h25; imem[4] = 8'h07; imem[5] = 8'hF0;
    push_exp(8'h16, 8'h00, 8'h00, 3, 8'h01);
    push_exp(8'h94, 8'h3C, 8'h01, 5, 8'h03);
    push_exp(8'h25, 8'h00, 8'h03, 3, 8'h04);
    push_exp(8'h07, 8'h00, 8'h04, 3, 8'h05);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) do_instr(1'b0, 8'h00, 0);
    seen = 0;
    instr_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (instr_valid) seen++;
    end
    instr_ready = 1'b0;
    check("hlt_valid_cycles", seen, 0);
    check("hlt_halted", halted, 1'b1);
    check("hlt_imem_addr", imem_addr, 8'h06);
    #3 rst_n = 1'b0;
    #1 check("hlt_async_clear_halted", halted, 1'b0);
    check("hlt_async_clear_addr", imem_addr, 8'h00);

    // Asynchronous reset in the middle of F_ADDR2.
    imem[0] = 8'h94; imem[1] = 8'h55;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("addr2_pre_instr", instr, 8'h94);
    check("addr2_pre_addr", imem_addr, 8'h01);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    imem[0] = 8'h16;
    push_exp(8'h16, 8'h00, 8'h00, 3, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    do_instr(1'b0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
